// File: rtl/clk_enable_gen_if.sv
// clk_enable_gen_if: control/status bundle for the fractional tick-enable generator
//   master drives: chan_en, phase_clr, wr_en, wr_sel, wr_data
//   slave drives:  pending, tick, sq_out, locked
interface clk_enable_gen_if #(
   parameter int NUM_CHANNELS = 4,
   parameter int ACC_WIDTH = 32
);
   localparam int SEL_W = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
   logic [NUM_CHANNELS-1:0] chan_en;
   logic phase_clr;
   logic wr_en;
   logic [SEL_W-1:0] wr_sel;
   logic [ACC_WIDTH-1:0] wr_data;
   logic [NUM_CHANNELS-1:0] pending;
   logic [NUM_CHANNELS-1:0] tick;
   logic [NUM_CHANNELS-1:0] sq_out;
   logic locked;
   modport master (
      output chan_en, phase_clr, wr_en, wr_sel, wr_data,
      input pending, tick, sq_out, locked
   );
   modport slave (
      input chan_en, phase_clr, wr_en, wr_sel, wr_data,
      output pending, tick, sq_out, locked
   );
endinterface

// File: rtl/clk_enable_gen.sv
// clk_enable_gen: NUM_CHANNELS phase-accumulator tick enables with square outputs and lock status
//   clk     system clock
//   reset_n synchronous active-low reset
//   bus     chan_en/phase_clr/wr_* in, pending/tick/sq_out/locked out (all registered)
module clk_enable_gen #(
   parameter int NUM_CHANNELS = 4,
   parameter int ACC_WIDTH = 32,
   parameter logic [NUM_CHANNELS*ACC_WIDTH-1:0] DEFAULT_INC = '0,
   parameter int LOCK_CYCLES = 16
) (
   input logic clk,
   input logic reset_n,
   clk_enable_gen_if.slave bus
);
   localparam int SEL_W = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
   localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
   logic [ACC_WIDTH-1:0] acc [NUM_CHANNELS];
   logic [ACC_WIDTH-1:0] inc [NUM_CHANNELS];
   logic [ACC_WIDTH-1:0] pend_data [NUM_CHANNELS];
   logic [ACC_WIDTH:0] sum [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] carry, apply, wr_hit;
   logic [NUM_CHANNELS-1:0] pending_q, tick_q, sq_q;
   logic [CNT_W-1:0] lock_cnt;
   logic locked_q;
   genvar i;
   for (i = 0; i < NUM_CHANNELS; i++) begin : g_ch
      assign sum[i] = {1'b0, acc[i]} + {1'b0, inc[i]};
      assign carry[i] = bus.chan_en[i] & sum[i][ACC_WIDTH];
      // a new increment only takes effect at a period boundary, while idle, or on realignment
      assign apply[i] = pending_q[i] & (carry[i] | ~bus.chan_en[i] | bus.phase_clr);
      assign wr_hit[i] = bus.wr_en & (bus.wr_sel == SEL_W'(i));
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            acc[c] <= '0;
            inc[c] <= DEFAULT_INC[c*ACC_WIDTH +: ACC_WIDTH];
            pend_data[c] <= '0;
         end
         pending_q <= '0;
         tick_q <= '0;
         sq_q <= '0;
         lock_cnt <= '0;
         locked_q <= 1'b0;
      end else begin
         lock_cnt <= lock_cnt + CNT_W'(lock_cnt != CNT_W'(LOCK_CYCLES));
         locked_q <= locked_q | (lock_cnt == CNT_W'(LOCK_CYCLES - 1));
         tick_q <= carry & ~{NUM_CHANNELS{bus.phase_clr}};
         sq_q <= bus.phase_clr ? '0 : sq_q ^ carry;
         // a write landing on the apply edge re-arms pending with the fresh value
         pending_q <= (pending_q & ~apply) | wr_hit;
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            acc[c] <= bus.phase_clr ? '0 : bus.chan_en[c] ? sum[c][ACC_WIDTH-1:0] : acc[c];
            if (apply[c]) inc[c] <= pend_data[c];
            if (wr_hit[c]) pend_data[c] <= bus.wr_data;
         end
      end
   end
   assign bus.pending = pending_q;
   assign bus.tick = tick_q;
   assign bus.sq_out = sq_q;
   assign bus.locked = locked_q;
endmodule

// File: tb/tb_clk_enable_gen.sv
// tb_clk_enable_gen: scoreboard bench for clk_enable_gen against a cycle model
module tb_clk_enable_gen;
   localparam int N = 4;
   localparam int AW = 32;
   localparam int LOCK = 16;
   localparam logic [N*AW-1:0] DEF = {32'h4000_0000, 32'h2000_0000, 32'h6000_0000, 32'h4000_0000};
   localparam longint unsigned MOD = 64'h1_0000_0000;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;
   clk_enable_gen_if #(.NUM_CHANNELS(N), .ACC_WIDTH(AW)) bus ();
   clk_enable_gen #(.NUM_CHANNELS(N), .ACC_WIDTH(AW), .DEFAULT_INC(DEF), .LOCK_CYCLES(LOCK)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );
   clk_enable_gen_if #(.NUM_CHANNELS(3), .ACC_WIDTH(AW)) bus3 ();
   clk_enable_gen #(.NUM_CHANNELS(3), .ACC_WIDTH(AW), .DEFAULT_INC('0), .LOCK_CYCLES(4)) dut3 (
      .clk(clk), .reset_n(reset_n), .bus(bus3)
   );
   typedef struct packed {
      logic [N-1:0] pending;
      logic [N-1:0] tick;
      logic [N-1:0] sq;
      logic locked;
   } exp_t;
   exp_t sb[$];
   longint unsigned m_acc [N];
   longint unsigned m_inc [N];
   longint unsigned m_pend [N];
   logic [N-1:0] m_pnd, m_tick, m_sq;
   int m_lcnt;
   logic m_locked;
   int n_assert = 0;
   int n_fail = 0;
   int cyc = 0;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   function automatic logic will_carry(input int i);
      return bus.chan_en[i] && (m_acc[i] + m_inc[i] >= MOD);
   endfunction
   task automatic model_step();
      exp_t e;
      if (!reset_n) begin
         for (int i = 0; i < N; i++) begin
            m_acc[i] = 0;
            m_inc[i] = DEF[i*AW +: AW];
            m_pend[i] = 0;
         end
         m_pnd = '0;
         m_tick = '0;
         m_sq = '0;
         m_lcnt = 0;
         m_locked = 1'b0;
      end else begin
         if (m_lcnt < LOCK) m_lcnt++;
         if (m_lcnt == LOCK) m_locked = 1'b1;
         for (int i = 0; i < N; i++) begin
            logic c;
            c = will_carry(i);
            m_acc[i] = bus.phase_clr ? 0 : bus.chan_en[i] ? (m_acc[i] + m_inc[i]) % MOD : m_acc[i];
            m_tick[i] = c && !bus.phase_clr;
            m_sq[i] = bus.phase_clr ? 1'b0 : m_sq[i] ^ c;
            if (m_pnd[i] && (c || !bus.chan_en[i] || bus.phase_clr)) begin
               m_inc[i] = m_pend[i];
               m_pnd[i] = 1'b0;
            end
            if (bus.wr_en && bus.wr_sel == i) begin
               m_pend[i] = bus.wr_data;
               m_pnd[i] = 1'b1;
            end
         end
      end
      e.pending = m_pnd;
      e.tick = m_tick;
      e.sq = m_sq;
      e.locked = m_locked;
      sb.push_back(e);
   endtask
   task automatic cycle();
      exp_t e;
      model_step();
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("pending", bus.pending, e.pending);
      chk("tick", bus.tick, e.tick);
      chk("sq_out", bus.sq_out, e.sq);
      chk("locked", bus.locked, e.locked);
      cyc = reset_n ? cyc + 1 : 0;
   endtask
   task automatic write(input int sel, input logic [AW-1:0] data);
      bus.wr_en = 1'b1;
      bus.wr_sel = 2'(sel);
      bus.wr_data = data;
      cycle();
      bus.wr_en = 1'b0;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
   initial begin
      int lock_at, t0c, t0_bad, t1c, t1n, t2c, gap, diff, k0;
      int t1_at [3];
      logic found;
      logic [5:0] pat;
      logic sq3;
      bus.chan_en = '1;
      bus.phase_clr = 1'b0;
      bus.wr_en = 1'b0;
      bus.wr_sel = '0;
      bus.wr_data = '0;
      bus3.chan_en = '0;
      bus3.phase_clr = 1'b0;
      bus3.wr_en = 1'b0;
      bus3.wr_sel = '0;
      bus3.wr_data = '0;
      reset_n = 1'b0;
      repeat (3) cycle();
      chk("reset_outputs", {bus.pending, bus.tick, bus.sq_out, bus.locked}, '0);
      reset_n = 1'b1;
      lock_at = -1;
      t0c = 0; t0_bad = 0; t1c = 0; t1n = 0; t2c = 0;
      t1_at[0] = 0; t1_at[1] = 0; t1_at[2] = 0;
      for (int k = 1; k <= 800; k++) begin
         cycle();
         if (bus.locked && lock_at < 0) lock_at = cyc;
         if (bus.tick[0]) begin
            t0c++;
            if (cyc % 4 != 0) t0_bad++;
         end
         if (bus.tick[1]) begin
            t1c++;
            if (t1n < 3) begin
               t1_at[t1n] = cyc;
               t1n++;
            end
         end
         if (bus.tick[2]) t2c++;
         if (cyc == 5) chk("sq0_high_after_tick4", bus.sq_out[0], 1'b1);
         if (cyc == 9) chk("sq0_low_after_tick8", bus.sq_out[0], 1'b0);
      end
      chk("lock_cycle", lock_at, 16);
      chk("tick0_count", t0c, 200);
      chk("tick0_offgrid", t0_bad, 0);
      chk("tick1_count", t1c, 300);
      chk("tick1_first", t1_at[0], 3);
      chk("tick1_second", t1_at[1], 6);
      chk("tick1_third", t1_at[2], 8);
      chk("tick2_count", t2c, 100);
      cycle();
      write(0, 32'h8000_0000);
      chk("reprog_pending_set", bus.pending[0], 1'b1);
      found = 1'b0;
      for (int k = 0; k < 8 && !found; k++) begin
         cycle();
         if (bus.tick[0]) found = 1'b1;
      end
      chk("reprog_tick_found", found, 1'b1);
      chk("reprog_pending_clr", bus.pending[0], 1'b0);
      pat = '0;
      repeat (6) begin
         cycle();
         pat = {pat[4:0], bus.tick[0]};
      end
      chk("reprog_tick_pattern", pat, 6'b010101);
      for (int k = 0; k < 16 && will_carry(2); k++) cycle();
      write(2, 32'h4000_0000);
      for (int k = 0; k < 16 && !will_carry(2); k++) cycle();
      write(2, 32'h1000_0000);
      chk("coll_tick", bus.tick[2], 1'b1);
      chk("coll_pending_held", bus.pending[2], 1'b1);
      gap = 0;
      for (int k = 1; k <= 16 && gap == 0; k++) begin
         cycle();
         if (bus.tick[2]) gap = k;
      end
      chk("coll_old_value_gap", gap, 4);
      chk("coll_new_applied", bus.pending[2], 1'b0);
      write(1, 32'h1000_0000);
      write(3, 32'h8000_0000);
      bus.chan_en[3] = 1'b0;
      sq3 = bus.sq_out[3];
      repeat (3) begin
         cycle();
         chk("dis_tick3", bus.tick[3], 1'b0);
         chk("dis_sq3_held", bus.sq_out[3], sq3);
      end
      chk("dis_pending3_applied", bus.pending[3], 1'b0);
      bus.chan_en[3] = 1'b1;
      repeat (5) cycle();
      bus.phase_clr = 1'b1;
      cycle();
      bus.phase_clr = 1'b0;
      chk("clr_outputs", {bus.pending, bus.tick, bus.sq_out}, '0);
      diff = 0;
      k0 = 0;
      repeat (16) begin
         cycle();
         if (bus.tick[0] != bus.tick[3]) diff++;
         if (bus.tick[0]) k0++;
      end
      chk("clr_coherent", diff, 0);
      chk("clr_tick0_count", k0, 8);
      repeat (3) cycle();
      reset_n = 1'b0;
      cycle();
      chk("midrun_reset", {bus.pending, bus.tick, bus.sq_out, bus.locked}, '0);
      reset_n = 1'b1;
      repeat (2) cycle();
      bus3.wr_en = 1'b1;
      bus3.wr_sel = 2'd2;
      bus3.wr_data = 32'h5;
      cycle();
      chk("n3_inrange_pending", bus3.pending, 3'b100);
      bus3.wr_sel = 2'd3;
      cycle();
      bus3.wr_en = 1'b0;
      chk("n3_outofrange_ignored", bus3.pending, 3'b000);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
